// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg - shared types for the five-stage MIPS core.
//
// Contents:
//   regbits_t       5-bit register index
//   word_t          32-bit datapath word
//   hazctl_state_t  hazard_ctrl sequencing states {RUN, DRAIN, HALTED}
//   load_use_hit()  load-use hazard detect between ID/EX load and IF/ID sources
package cpu_types_pkg;

  localparam int REG_W  = 5;
  localparam int WORD_W = 32;

  typedef logic [REG_W-1:0]  regbits_t;
  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } hazctl_state_t;

  // $zero is never a real dependency: loads into r0 are discarded.
  function automatic logic load_use_hit(
    input logic     memread,
    input regbits_t ld_rt,
    input regbits_t src_rs,
    input regbits_t src_rt
  );
    return memread && (ld_rt != '0) && ((ld_rt == src_rs) || (ld_rt == src_rt));
  endfunction

endpackage

// File: rtl/hazctl_perf.sv
// hazctl_perf - stall/flush performance counters for hazard_ctrl.
//
// Ports:
//   CLK        clock, rising edge
//   nRST       asynchronous active-low reset (counters clear to 0)
//   stall_evt  count one stall cycle (caller gates with RUN state)
//   flush_evt  count one redirect flush (caller gates with RUN state)
//   stall_cnt  saturating stall-cycle count
//   flush_cnt  saturating redirect-flush count
//
// Both counters stop at all-ones instead of wrapping.
module hazctl_perf
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              stall_evt,
  input  logic              flush_evt,
  output logic [WORD_W-1:0] stall_cnt,
  output logic [WORD_W-1:0] flush_cnt
);

  word_t stall_cnt_reg;
  word_t flush_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (flush_evt && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl - pipeline sequencing controller for the five-stage MIPS core.
//
// Drives enable/flush of every pipeline latch and the PC enable from cache
// handshakes, load-use hazards, control-flow redirects and HALT. Owns the
// RUN -> DRAIN -> HALTED halt-drain state machine. Inside a latch, flush
// wins over enable (the latch loads zeros).
//
// Ports:
//   CLK, nRST                 clock (rising) / asynchronous active-low reset
//   ihit, dhit                I-fetch / data access complete this cycle
//   mem_req                   EX/MEM instruction performs a memory access
//   idex_memread, idex_rt     ID/EX load and its destination register
//   ifid_rs, ifid_rt          source registers of the instruction in ID
//   jump_id                   J/JAL/JR decoded in ID
//   branch_mem                taken branch resolved in MEM
//   halt_mem                  HALT reached MEM
//   pc_en                     PC update enable
//   ifid/idex/exmem/memwb_en, _flush   latch controls (combinational)
//   halt                      registered, sticky halt indication
//   stall_cnt, flush_cnt      performance counters
//
// Build option: define HAZCTL_PERF_EN to build the stall/flush counters
// (hazctl_perf). Without it both counter ports read constant 0.
module hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              mem_req,
  input  logic              idex_memread,
  input  logic [REG_W-1:0]  idex_rt,
  input  logic [REG_W-1:0]  ifid_rs,
  input  logic [REG_W-1:0]  ifid_rt,
  input  logic              jump_id,
  input  logic              branch_mem,
  input  logic              halt_mem,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              exmem_en,
  output logic              exmem_flush,
  output logic              memwb_en,
  output logic              memwb_flush,
  output logic              halt,
  output logic [WORD_W-1:0] stall_cnt,
  output logic [WORD_W-1:0] flush_cnt
);

  hazctl_state_t state_reg;
  logic          halt_reg;

  logic memstall;
  logic load_use;

  assign memstall = mem_req && !dhit;
  assign load_use = load_use_hit(idex_memread, idex_rt, ifid_rs, ifid_rt);

  // State and sticky halt. halt follows HALTED by one edge so it reflects
  // a fully drained pipeline rather than the transition itself.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          // memstall outranks halt_mem, so only a non-stalled HALT drains.
          if (!memstall && halt_mem)
            state_reg <= DRAIN;
        end
        DRAIN:   state_reg <= HALTED;
        HALTED:  state_reg <= HALTED;
        default: state_reg <= RUN;
      endcase
      if (state_reg == HALTED)
        halt_reg <= 1'b1;
    end
  end

  assign halt = halt_reg;

  // Latch controls. Priority chain in RUN, highest first:
  // memstall, halt_mem, branch_mem, load-use, jump_id, !ihit.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    memwb_flush = 1'b0;

    if (state_reg != RUN) begin
      // DRAIN/HALTED: freeze everything.
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (memstall) begin
      // Hold IF..EX/MEM; MEM/WB takes a bubble while the access completes.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (halt_mem) begin
      // Let HALT retire into MEM/WB, squash everything younger.
      pc_en       = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (branch_mem) begin
      // Redirect takes effect even without ihit: the fetched word is junk.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID for one cycle, bubble into ID/EX.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (jump_id) begin
      ifid_flush = 1'b1;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZCTL_PERF_EN
  logic stall_evt;
  logic flush_evt;

  // Counters only advance in RUN; DRAIN/HALTED freeze them.
  assign stall_evt = (state_reg == RUN) && !pc_en;
  assign flush_evt = (state_reg == RUN) && !memstall && !halt_mem &&
                     (branch_mem || (jump_id && !load_use));

  hazctl_perf u_perf (
    .CLK       (CLK),
    .nRST      (nRST),
    .stall_evt (stall_evt),
    .flush_evt (flush_evt),
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl - directed, table-driven bench for hazard_ctrl.
// Compile with +define+HAZCTL_PERF_EN to also check live counter values.
module tb_hazard_ctrl;

`ifdef HAZCTL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Output pattern order:
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
  localparam logic [8:0] P_NORM  = 9'b110101010;
  localparam logic [8:0] P_MST   = 9'b000000011;
  localparam logic [8:0] P_BR    = 9'b111111110;
  localparam logic [8:0] P_LU    = 9'b000111010;
  localparam logic [8:0] P_JMP   = 9'b111101010;
  localparam logic [8:0] P_NOHIT = 9'b011101010;
  localparam logic [8:0] P_HALT  = 9'b011111110;
  localparam logic [8:0] P_IDLE  = 9'b000000000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, mem_req, idex_memread;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        jump_id, branch_mem, halt_mem;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
  logic [31:0] stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  hazard_ctrl dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .dhit         (dhit),
    .mem_req      (mem_req),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .jump_id      (jump_id),
    .branch_mem   (branch_mem),
    .halt_mem     (halt_mem),
    .pc_en        (pc_en),
    .ifid_en      (ifid_en),
    .ifid_flush   (ifid_flush),
    .idex_en      (idex_en),
    .idex_flush   (idex_flush),
    .exmem_en     (exmem_en),
    .exmem_flush  (exmem_flush),
    .memwb_en     (memwb_en),
    .memwb_flush  (memwb_flush),
    .halt         (halt),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    string      name;
    logic       ihit, dhit, mem_req, memread;
    logic [4:0] idex_rt, ifid_rs, ifid_rt;
    logic       jump, branch;
    logic [8:0] exp;
    logic       fev;
  } vec_t;

  vec_t vecs [14];

  function automatic logic [8:0] outs();
    return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
            exmem_en, exmem_flush, memwb_en, memwb_flush};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end else begin
      $display("ok   %s got=%h", nm, got);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; mem_req = 1'b0; idex_memread = 1'b0;
    idex_rt = '0; ifid_rs = '0; ifid_rt = '0;
    jump_id = 1'b0; branch_mem = 1'b0; halt_mem = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
  endtask

  int m_stall, m_flush;

  initial begin
    vecs[0]  = '{"normal",    1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, P_NORM,  0};
    vecs[1]  = '{"lu_rs",     1,0,0,1, 5'd5, 5'd5, 5'd0, 0,0, P_LU,    0};
    vecs[2]  = '{"lu_rt",     1,0,0,1, 5'd7, 5'd3, 5'd7, 0,0, P_LU,    0};
    vecs[3]  = '{"lu_r0",     1,0,0,1, 5'd0, 5'd0, 5'd0, 0,0, P_NORM,  0};
    vecs[4]  = '{"noload",    1,0,0,0, 5'd5, 5'd5, 5'd5, 0,0, P_NORM,  0};
    vecs[5]  = '{"memstall",  0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0, P_MST,   0};
    vecs[6]  = '{"memhit",    1,1,1,0, 5'd0, 5'd0, 5'd0, 0,0, P_NORM,  0};
    vecs[7]  = '{"br_lu",     0,0,0,1, 5'd5, 5'd5, 5'd0, 0,1, P_BR,    1};
    vecs[8]  = '{"jump",      1,0,0,0, 5'd0, 5'd0, 5'd0, 1,0, P_JMP,   1};
    vecs[9]  = '{"jmp_lu",    1,0,0,1, 5'd9, 5'd1, 5'd9, 1,0, P_LU,    0};
    vecs[10] = '{"nohit",     0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0, P_NOHIT, 0};
    vecs[11] = '{"jmp_nohit", 0,0,0,0, 5'd0, 5'd0, 5'd0, 1,0, P_JMP,   1};
    vecs[12] = '{"mst_br",    1,0,1,0, 5'd0, 5'd0, 5'd0, 0,1, P_MST,   0};
    vecs[13] = '{"lu_nohit",  0,0,0,1, 5'd4, 5'd4, 5'd0, 0,0, P_LU,    0};

    // Reset state
    do_reset();
    #1;
    chk("rst_outs",  {23'd0, outs()}, {23'd0, P_NORM});
    chk("rst_halt",  {31'd0, halt}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);

    // Table: combinational controls in RUN plus counter model
    m_stall = 0; m_flush = 0;
    for (int i = 0; i < 14; i++) begin
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; mem_req = vecs[i].mem_req;
      idex_memread = vecs[i].memread; idex_rt = vecs[i].idex_rt;
      ifid_rs = vecs[i].ifid_rs; ifid_rt = vecs[i].ifid_rt;
      jump_id = vecs[i].jump; branch_mem = vecs[i].branch; halt_mem = 1'b0;
      #1;
      chk(vecs[i].name, {23'd0, outs()}, {23'd0, vecs[i].exp});
      @(posedge CLK); #1;
      if (!vecs[i].exp[8]) m_stall++;
      if (vecs[i].fev) m_flush++;
      chk({vecs[i].name, "_scnt"}, stall_cnt, PERF ? 32'(m_stall) : 32'd0);
      chk({vecs[i].name, "_fcnt"}, flush_cnt, PERF ? 32'(m_flush) : 32'd0);
    end

    // Load-use: exactly one bubble, then the freed ID/EX clears the hazard
    do_reset();
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 chk("lu_seq_c0", {23'd0, outs()}, {23'd0, P_LU});
    @(posedge CLK); #1;
    idex_memread = 1'b0; idex_rt = 5'd0;
    #1 chk("lu_seq_c1", {23'd0, outs()}, {23'd0, P_NORM});
    @(posedge CLK); #1;
    chk("lu_seq_scnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Memory stall for three cycles, then resume
    do_reset();
    mem_req = 1'b1; dhit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("mst_seq_c%0d", c), {23'd0, outs()}, {23'd0, P_MST});
      @(posedge CLK); #1;
    end
    dhit = 1'b1;
    #1 chk("mst_seq_resume", {23'd0, outs()}, {23'd0, P_NORM});
    @(posedge CLK); #1;
    mem_req = 1'b0; dhit = 1'b0;
    chk("mst_seq_scnt", stall_cnt, PERF ? 32'd3 : 32'd0);

    // Branch beats load-use with ihit low
    do_reset();
    ihit = 1'b0; branch_mem = 1'b1;
    idex_memread = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    #1 chk("br_seq", {23'd0, outs()}, {23'd0, P_BR});
    @(posedge CLK); #1;
    idle_inputs();
    chk("br_seq_fcnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    chk("br_seq_scnt", stall_cnt, 32'd0);

    // Halt drain: halt_mem sampled at edge N
    do_reset();
    halt_mem = 1'b1;
    #1 chk("halt_c0", {23'd0, outs()}, {23'd0, P_HALT});
    @(posedge CLK); #1;                       // edge N -> DRAIN
    halt_mem = 1'b0;
    #1 chk("halt_drain", {23'd0, outs()}, {23'd0, P_IDLE});
    chk("halt_drain_h", {31'd0, halt}, 32'd0);
    @(posedge CLK); #1;                       // edge N+1 -> HALTED
    chk("halt_n1_h", {31'd0, halt}, 32'd0);
    chk("halt_n1", {23'd0, outs()}, {23'd0, P_IDLE});
    @(posedge CLK); #1;                       // edge N+2 -> halt=1
    chk("halt_n2_h", {31'd0, halt}, 32'd1);
    for (int c = 0; c < 4; c++) begin
      ihit = c[0]; dhit = c[1]; mem_req = c[0];
      @(posedge CLK); #1;
      chk($sformatf("halt_hold%0d", c), {22'd0, halt, outs()}, {22'd0, 1'b1, P_IDLE});
    end
    chk("halt_scnt", stall_cnt, PERF ? 32'd1 : 32'd0);

    // Asynchronous reset while in DRAIN
    do_reset();
    halt_mem = 1'b1;
    @(posedge CLK); #1;
    halt_mem = 1'b0;
    #1 chk("ard_drain", {23'd0, outs()}, {23'd0, P_IDLE});
    #1 nRST = 1'b0;
    #1;
    chk("ard_outs",  {23'd0, outs()}, {23'd0, P_NORM});
    chk("ard_halt",  {31'd0, halt}, 32'd0);
    chk("ard_scnt",  stall_cnt, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    @(posedge CLK); #1;
    chk("ard_run", {23'd0, outs()}, {23'd0, P_NORM});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. Each cycle it drives the enable/flush pair of every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable from cache handshakes, the load-use hazard, control-flow redirects and HALT. It owns the halt-drain state machine and the optional stall/flush performance counters. Flush has priority over enable inside every latch, so a latch loads zeros whenever its flush is 1.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- ihit  in  1  instruction fetch completes this cycle.
- dhit  in  1  data access completes this cycle.
- mem_req  in  1  EX/MEM instruction has dREN or dWEN.
- idex_memread  in  1  ID/EX instruction is a load.
- idex_rt  in  5  load destination (regbits_t).
- ifid_rs, ifid_rt  in  5 each  ID source registers.
- jump_id  in  1  J/JAL/JR decoded in ID.
- branch_mem  in  1  taken branch resolved in MEM.
- halt_mem  in  1  HALT in MEM.
- pc_en  out  1  PC update.
- ifid_en, ifid_flush  out  1 each  IF/ID latch controls.
- idex_en, idex_flush  out  1 each  ID/EX latch controls.
- exmem_en, exmem_flush  out  1 each  EX/MEM latch controls.
- memwb_en, memwb_flush  out  1 each  MEM/WB latch controls.
- halt  out  1  registered, sticky.
- stall_cnt, flush_cnt  out  32 each  performance counters.

## Operation
FSM states: RUN, DRAIN, HALTED. Reset values: state=RUN, halt=0, counters=0.

Priority in RUN, highest first. Outputs not listed are en=1, flush=0.
- memstall (mem_req & !dhit): pc_en, ifid_en, idex_en and exmem_en are 0; memwb_flush=1.
- halt_mem: pc_en=0; ifid_flush, idex_flush, exmem_flush are 1; memwb_en=1; next state DRAIN.
- branch_mem: pc_en=1 regardless of ihit; ifid_flush, idex_flush, exmem_flush are 1.
- load-use: idex_memread & idex_rt!=0 & (idex_rt==ifid_rs | idex_rt==ifid_rt). pc_en=0, ifid_en=0, idex_flush=1.
- jump_id: pc_en=1 regardless of ihit; ifid_flush=1.
- !ihit: pc_en=0; ifid_flush=1, which inserts a bubble while downstream stages advance.
- Otherwise: all enables 1, all flushes 0.

Other states:
- DRAIN: all en and flush are 0; next state HALTED.
- HALTED: all en and flush are 0; halt=1; the state holds until reset.

Simultaneous-event rules:
- Load-use beats jump_id, so a JR on a loaded register waits.
- branch_mem beats load-use, because the squashed instructions make the hazard moot.
- halt_mem is never paired with memstall, since HALT issues no memory op.

Reset asserted mid-operation (any state, including DRAIN) returns to RUN with all outputs at their reset values.

## Timing
- Latch enable/flush outputs and pc_en are combinational from inputs and state, valid within the same cycle.
- halt_mem sampled at edge N: DRAIN during N..N+1, HALTED from edge N+1; halt=1 from edge N+2.
- Load-use costs exactly one bubble. Each memstall cycle costs one cycle.
- Counters update on the rising edge and are visible the following cycle.

## Configuration
- HAZCTL_PERF_EN defined:
  - stall_cnt increments each RUN cycle with pc_en=0.
  - flush_cnt increments each RUN cycle with branch_mem or jump_id taking effect.
  - Both saturate at 32'hFFFFFFFF and freeze in DRAIN/HALTED.
- HAZCTL_PERF_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Add to cpu_types_pkg: hazctl_state_t enum {RUN, DRAIN, HALTED}. regbits_t and word_t come from the same package.
- One sub-module, hazctl_perf, holds the two saturating counters. It is instantiated only under HAZCTL_PERF_EN.

## Test plan
- Reset, then ihit=1 and no hazards → all en=1, all flush=0, halt=0, counters 0.
- idex_memread=1, idex_rt=5, ifid_rs=5, ihit=1 → pc_en=0, ifid_en=0, idex_flush=1 for exactly one cycle. Repeat with idex_rt=0 → no stall.
- mem_req=1, dhit low for 3 cycles → pc_en/ifid_en/idex_en/exmem_en=0 and memwb_flush=1 for 3 cycles, then resume. With PERF, stall_cnt=3.
- branch_mem=1, ihit=0, with a load-use also present → pc_en=1; ifid/idex/exmem flush=1; no load-use stall. With PERF, flush_cnt=1.
- halt_mem at edge N → flushes and memwb_en=1 that cycle. halt=1 from edge N+2 and stays 1 despite ihit/dhit toggling.
- nRST pulsed low while in DRAIN → state RUN, halt=0, counters 0 immediately (asynchronous).
